// File: rtl/stream_dma_reader_if.sv
// Bus bundle for stream_dma_reader: CSR slave port, memory read master, stream source.
// The master modport is the engine's view; slave is the surrounding system's view.
interface stream_dma_reader_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  logic        aso_valid;
  logic [31:0] aso_data;
  logic        aso_ready;

  modport master (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata,
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output aso_valid, aso_data,
    input  aso_ready
  );

  modport slave (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata,
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  aso_valid, aso_data,
    output aso_ready
  );
endinterface

// File: rtl/stream_dma_reader.sv
// Memory-to-stream read engine: credit-limited Avalon-MM reads feeding a show-ahead
// FIFO that drives an Avalon-ST source, controlled by a four-register CSR block.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no transfer; START with LENGTH != 0 launches one
// S_ISSUE | issuing reads while words remain and credit allows
// S_DRAIN | all reads accepted; waiting for returns and FIFO to empty
module stream_dma_reader #(
  parameter int FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 reset,
  stream_dma_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   addr_reg, length_reg;
  logic [31:0]   cur_addr, remaining, remaining_nxt;
  logic [CW-1:0] pending, pending_nxt;
  logic [CW-1:0] fifo_count, count_nxt;
  logic [CW:0]   occupancy, occupancy_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   mem [FIFO_DEPTH];
  logic          avm_read_q, read_nxt;
  logic          done, busy;
  logic          start, accept, ret, pop, fifo_valid;
  logic          drain_done;

  always_comb begin
    start      = bus.avs_write && (bus.avs_address == 2'd2) && bus.avs_writedata[0];
    accept     = avm_read_q && !bus.avm_waitrequest;
    // Returns with nothing pending belong to a transfer abandoned by reset.
    ret        = bus.avm_readdatavalid && (pending != '0);
    fifo_valid = (fifo_count != '0);
    pop        = fifo_valid && bus.aso_ready;

    pending_nxt   = pending + CW'(accept) - CW'(ret);
    count_nxt     = fifo_count + CW'(ret) - CW'(pop);
    remaining_nxt = accept ? remaining - 32'd1 : remaining;
    occupancy     = {1'b0, pending} + {1'b0, fifo_count};
    occupancy_nxt = {1'b0, pending_nxt} + {1'b0, count_nxt};
    drain_done    = (pending_nxt == '0) && (count_nxt == '0);
    busy          = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    read_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (length_reg != 32'd0)) begin
          state_nxt = S_ISSUE;
          read_nxt  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (accept && (remaining == 32'd1)) state_nxt = S_DRAIN;
        // A raised request stays up until accepted, whatever the credit.
        if (avm_read_q && bus.avm_waitrequest)
          read_nxt = 1'b1;
        else
          read_nxt = (remaining_nxt != 32'd0) &&
                     (occupancy_nxt < (CW+1)'(FIFO_DEPTH));
      end
      S_DRAIN: begin
        if (drain_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg   <= '0;
      length_reg <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
      pending    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      avm_read_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (bus.avs_write && (bus.avs_address == 2'd0))
        addr_reg <= {bus.avs_writedata[31:2], 2'b00};
      if (bus.avs_write && (bus.avs_address == 2'd1))
        length_reg <= bus.avs_writedata;

      avm_read_q <= read_nxt;
      pending    <= pending_nxt;
      fifo_count <= count_nxt;
      if (ret) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      if ((state == S_IDLE) && start) begin
        if (length_reg != 32'd0) begin
          cur_addr  <= addr_reg;
          remaining <= length_reg;
          done      <= 1'b0;
        end else begin
          done <= 1'b1;
        end
      end else begin
        if (accept) begin
          cur_addr  <= cur_addr + 32'd4;
          remaining <= remaining_nxt;
        end
        if ((state == S_DRAIN) && drain_done) done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ret) mem[wr_ptr] <= bus.avm_readdata;
  end

  assign bus.avm_read    = avm_read_q;
  assign bus.avm_address = cur_addr;
  assign bus.aso_valid   = fifo_valid;
  assign bus.aso_data    = fifo_valid ? mem[rd_ptr] : 32'd0;

  always_comb begin
    bus.avs_readdata = 32'd0;
    if (bus.avs_read) begin
      case (bus.avs_address)
        2'd0:    bus.avs_readdata = addr_reg;
        2'd1:    bus.avs_readdata = length_reg;
        2'd3:    bus.avs_readdata = {16'(occupancy), 14'd0, done, busy};
        default: bus.avs_readdata = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_dma_reader.sv
// Bench for stream_dma_reader: a latency/stall memory responder and stream sink driven
// from one thread, checked against a transfer-level model of addresses, words and status.
module tb_stream_dma_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_dma_reader_if bus ();
  stream_dma_reader #(.FIFO_DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] base;
    int          len;
    int          lat;
    int          wait_pct;
    int          ready_pct;
    logic [31:0] exp_status;
    int          exp_words;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat_cfg  = 1;
  int wait_pct = 0;
  int ready_pct = 100;

  mreq_t       mem_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_len  = 32'd0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          occ = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check state left by the previous edge, then drive the next edge.
  task automatic step();
    mreq_t r;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      chk("stall_read_held", bus.avm_read, 1);
      chk("stall_addr_held", bus.avm_address, prev_addr);
    end
    if (bus.avs_read && bus.avs_address == 2'd3)
      chk("status", bus.avs_readdata, {16'(occ), 14'd0, m_done, m_busy});

    bus.avm_waitrequest = ($urandom_range(99) < wait_pct);
    bus.aso_ready       = ($urandom_range(99) < ready_pct);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'd0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = mem_word(r.addr);
    end

    if (bus.avm_read && !bus.avm_waitrequest) begin
      chk("read_expected", 32'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) chk("read_addr", bus.avm_address, exp_addr_q.pop_front());
      r.addr = bus.avm_address;
      r.due  = cyc + lat_cfg;
      mem_q.push_back(r);
      acc_cnt++;
      occ++;
    end
    prev_stall = bus.avm_read && bus.avm_waitrequest;
    prev_addr  = bus.avm_address;

    if (bus.aso_valid && bus.aso_ready) begin
      chk("word_expected", 32'(exp_data_q.size() != 0), 1);
      if (exp_data_q.size() != 0) chk("stream_data", bus.aso_data, mem_word(exp_data_q.pop_front()));
      occ--;
      pop_cnt++;
      if (m_busy && exp_data_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_read      = 1'b0;
    bus.avs_address   = a;
    bus.avs_write     = 1'b1;
    bus.avs_writedata = d;
    if (a == 2'd0) m_addr = {d[31:2], 2'b00};
    if (a == 2'd1) m_len  = d;
    if (a == 2'd2 && d[0] && !m_busy) begin
      if (m_len == 32'd0) m_done = 1'b1;
      else begin
        m_done  = 1'b0;
        m_busy  = 1'b1;
        acc_cnt = 0;
        pop_cnt = 0;
        for (int i = 0; i < int'(m_len); i++) begin
          exp_addr_q.push_back(m_addr + 32'(4 * i));
          exp_data_q.push_back(m_addr + 32'(4 * i));
        end
      end
    end
    step();
    bus.avs_write   = 1'b0;
    bus.avs_read    = 1'b1;
    bus.avs_address = 2'd3;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && m_busy; i++) step();
    chk("transfer_finished", 32'(m_busy), 0);
    step();
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input int lat,
                          input int wp, input int rp, input int budget);
    lat_cfg = lat; wait_pct = wp; ready_pct = rp;
    csr_write(2'd0, base);
    csr_write(2'd1, 32'(len));
    bus.avs_address = 2'd0; #1 chk("csr_addr", bus.avs_readdata, m_addr);
    bus.avs_address = 2'd1; #1 chk("csr_length", bus.avs_readdata, m_len);
    bus.avs_address = 2'd2; #1 chk("csr_control_reads_0", bus.avs_readdata, 0);
    bus.avs_address = 2'd3;
    csr_write(2'd2, 32'd1);
    #1;
    chk("start_busy", bus.avs_readdata[0], 1);
    chk("start_read", bus.avm_read, 1);
    chk("start_addr", bus.avm_address, m_addr);
    wait_idle(budget);
  endtask

  task automatic model_reset();
    exp_addr_q.delete();
    exp_data_q.delete();
    m_addr = 32'd0; m_len = 32'd0;
    m_busy = 1'b0;  m_done = 1'b0;
    occ = 0; acc_cnt = 0; pop_cnt = 0;
    prev_stall = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_1000,  8,  3,  0, 100, 32'h2,  8};
    vecs[1] = '{32'h0000_2000, 20,  2, 50, 100, 32'h2, 20};
    vecs[2] = '{32'h3000_0013, 12,  1,  0,  40, 32'h2, 12};
    vecs[3] = '{32'hFFFF_FFF8,  4,  2,  0, 100, 32'h2,  4};
    vecs[4] = '{32'h0000_4000, 30,  7, 20,  70, 32'h2, 30};
    vecs[5] = '{32'h0000_5004,  1,  1,  0, 100, 32'h2,  1};
    vecs[6] = '{32'h0000_6000, 20, 18,  0, 100, 32'h2, 20};

    reset = 1'b1;
    bus.avs_address = 2'd3; bus.avs_read = 1'b1; bus.avs_write = 1'b0; bus.avs_writedata = 32'd0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = 32'd0; bus.avm_readdatavalid = 1'b0;
    bus.aso_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_avm_read", bus.avm_read, 0);
    chk("rst_avm_address", bus.avm_address, 0);
    chk("rst_aso_valid", bus.aso_valid, 0);
    chk("rst_aso_data", bus.aso_data, 0);
    for (int a = 0; a < 4; a++) begin
      bus.avs_address = 2'(a);
      #1 chk("rst_csr", bus.avs_readdata, 0);
    end
    bus.avs_address = 2'd3;
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].lat, vecs[i].wait_pct, vecs[i].ready_pct, 3000);
      chk("vec_words", 32'(pop_cnt), 32'(vecs[i].exp_words));
      chk("vec_status", bus.avs_readdata, vecs[i].exp_status);
    end

    // Zero length: done immediately, no read issued.
    csr_write(2'd1, 32'd0);
    csr_write(2'd2, 32'd1);
    #1 chk("zero_len_status", bus.avs_readdata, 32'h2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("zero_len_no_read", bus.avm_read, 0);
    end

    // START and ADDR/LENGTH rewrite during a running transfer.
    lat_cfg = 3; wait_pct = 0; ready_pct = 50;
    csr_write(2'd0, 32'h0000_7000);
    csr_write(2'd1, 32'd10);
    csr_write(2'd2, 32'd1);
    repeat (3) step();
    csr_write(2'd0, 32'h0000_9000);
    csr_write(2'd1, 32'd3);
    csr_write(2'd2, 32'd1);
    wait_idle(2000);
    chk("busy_start_words", 32'(pop_cnt), 10);
    chk("busy_start_status", bus.avs_readdata, 32'h2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_start_no_restart", bus.avm_read, 0);
    end

    // Credit: sink stalled for 100 cycles on a 40-word transfer.
    lat_cfg = 2; wait_pct = 0; ready_pct = 0;
    csr_write(2'd0, 32'h0001_0000);
    csr_write(2'd1, 32'd40);
    csr_write(2'd2, 32'd1);
    repeat (100) step();
    chk("credit_accepts", 32'(acc_cnt), 16);
    chk("credit_occupancy", bus.avs_readdata[31:16], 16);
    ready_pct = 100;
    wait_idle(2000);
    chk("credit_words", 32'(pop_cnt), 40);

    // Reset after 5 of 12 reads accepted, with responses still in flight.
    lat_cfg = 3; wait_pct = 0; ready_pct = 0;
    csr_write(2'd0, 32'h0000_8000);
    csr_write(2'd1, 32'd12);
    csr_write(2'd2, 32'd1);
    for (int i = 0; i < 60 && acc_cnt < 5; i++) step();
    chk("accepts_before_reset", 32'(acc_cnt), 5);
    step();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_aso_valid", bus.aso_valid, 0);
    chk("post_reset_avm_read", bus.avm_read, 0);
    chk("post_reset_status", bus.avs_readdata, 0);
    ready_pct = 100;
    repeat (8) step();
    chk("late_data_dropped", bus.aso_valid, 0);
    chk("late_data_occupancy", bus.avs_readdata, 0);
    run_xfer(32'h0000_A000, 4, 2, 0, 100, 500);
    chk("after_reset_words", 32'(pop_cnt), 4);

    // Randomized transfers against the model.
    for (int t = 0; t < 20; t++) begin
      run_xfer($urandom, $urandom_range(24, 1), $urandom_range(8, 1),
               $urandom_range(60, 0), $urandom_range(100, 20), 5000);
      chk("rand_status", bus.avs_readdata, 32'h2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/stream_dma_reader.md
# stream_dma_reader

Memory-to-stream read engine: fetches LENGTH 32-bit words from memory over an Avalon-MM read master and presents them, in order, on an Avalon-ST source. It is the source end of the DMA read path feeding the stream processor's Avalon-ST sink. Software controls it through a small Avalon-MM CSR slave. Outstanding reads are credit-limited, so the internal FIFO can never overflow under backpressure.

## Interface
- FIFO_DEPTH, 16, read-data FIFO depth in words; power of two, ≥ 4; also the maximum outstanding reads
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- avs_address  in  2  CSR word select: 0 ADDR, 1 LENGTH, 2 CONTROL, 3 STATUS
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_read  in  1  CSR read strobe
- avs_readdata  out  32  CSR read data, zero read latency (combinational from registers)
- avm_address  out  32  byte address, always word aligned
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; request held while high
- avm_readdata  in  32  returned word
- avm_readdatavalid  in  1  avm_readdata valid this cycle
- aso_valid  out  1  stream word available
- aso_data  out  32  stream word
- aso_ready  in  1  downstream accepts

## Operation
- CSR ADDR (rw): byte base address; bits [1:0] are written as 0. LENGTH (rw): word count. CONTROL (wo): bit0 = start; reads return 0. STATUS (ro): bit0 busy, bit1 done (sticky), bits [31:16] = outstanding reads plus FIFO occupancy.
- ADDR/LENGTH are writable at any time. START copies them into working registers cur_addr and remaining; a transfer in progress uses only the working copies.
- FSM IDLE → ISSUE → DRAIN → IDLE.
- IDLE:
  - START with LENGTH ≠ 0 → ISSUE; done cleared, busy set.
  - START with LENGTH = 0 → stays IDLE and sets done.
- ISSUE:
  - avm_read is raised only when remaining > 0 and pending + fifo_count < FIFO_DEPTH (pending = accepted reads not yet returned).
  - Once raised, avm_read and avm_address hold stable until accepted (avm_read && !avm_waitrequest), regardless of credit.
  - On accept: cur_addr += 4, remaining −= 1, pending += 1.
  - Accept of the last word → DRAIN; avm_read deasserts the next cycle.
- DRAIN: when pending = 0 and FIFO is empty → IDLE; busy cleared and done set on the same edge.
- avm_readdatavalid pushes avm_readdata into the FIFO and decrements pending. An accept and a return in the same cycle leave pending unchanged.
- FIFO:
  - Show-ahead: aso_valid = !empty, aso_data = head word.
  - Pop on aso_valid && aso_ready.
  - Push and pop in the same cycle leave the count unchanged; a push to a full FIFO is impossible by credit.
  - Pop on empty is ignored.
- START while busy is ignored; ADDR/LENGTH writes while busy do not disturb the transfer.
- cur_addr wraps modulo 2^32; no special handling.
- Arithmetic: remaining 32 bits; pending and fifo_count each $clog2(FIFO_DEPTH)+1 bits.
- Reset values: avm_read 0, avm_address 0, aso_valid 0, aso_data 0, avs_readdata 0, ADDR 0, LENGTH 0, busy 0, done 0, FIFO empty, pending 0, FSM IDLE.
- Reset asserted mid-transfer: abandons the transfer and returns everything to reset values next edge. Read responses arriving after reset are discarded (pending = 0 drops them).

## Timing
- START written at cycle T → busy = 1 and avm_read = 1 at T+1, avm_address = ADDR.
- With waitrequest low and enough credit, one read issues per cycle.
- Word returned with readdatavalid at cycle R → aso_valid = 1 with that word at R+1.
- Sustained throughput: 1 word/cycle when the memory latency is below FIFO_DEPTH cycles and aso_ready is held high.
- Last word popped at cycle P → busy = 0 and done = 1 at P+1.
- CSR reads reflect register state in the same cycle; CSR writes take effect next edge.

## Test plan
- Basic transfer: ADDR=0x1000, LENGTH=8, START; memory model with 3-cycle latency, no waitrequest, aso_ready=1 → addresses 0x1000..0x101C issued once each; 8 words emitted in order; done=1, busy=0.
- Waitrequest: random waitrequest 50%, LENGTH=20 → avm_address/avm_read stable during every stall; no duplicate or skipped address; 20 words in order.
- Backpressure/credit: aso_ready=0 for 100 cycles, LENGTH=40, FIFO_DEPTH=16 → at most 16 reads accepted, pending + fifo_count never > 16; after release all 40 words arrive intact.
- Zero length and busy START: LENGTH=0 START → no avm_read, done=1 next cycle; START plus ADDR change during a 10-word transfer → original transfer unaffected, no restart.
- Mid-transfer reset: synchronous reset after 5 of 12 words are accepted, with late readdatavalid pulses → aso_valid=0, avm_read=0, STATUS=0 after reset; late data not emitted; a new 4-word transfer runs correctly.
- Simultaneous events: readdatavalid, pop, and accept all in the same cycle, plus address wrap from ADDR=0xFFFFFFF8, LENGTH=4 → counts stay correct; addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
